// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined SINGLE transfers,
// one response per command. Optional stall watchdog enabled with `define AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        timeout
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } trans_t;

  // Cancel tracker: WAIT until the errored transfer completes, then REPORT the cancelled one.
  typedef enum logic [1:0] {
    CXL_IDLE,
    CXL_WAIT,
    CXL_REPORT
  } cxl_state_t;

  trans_t      ap_trans;
  logic [31:0] ap_addr;
  logic        ap_write;
  logic [2:0]  ap_size;
  logic [31:0] ap_wdata;

  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_wdata;

  cxl_state_t  cxl_state, cxl_next;

  logic bus_accept;
  logic cancel_pending;
  logic cancel_evt;
  logic dp_done;

  assign bus_accept     = (ap_trans == TRANS_IDLE) || HREADY;
  assign cancel_pending = (cxl_state != CXL_IDLE);
  assign dp_done        = dp_valid && HREADY;
  // First ERROR cycle: slave signals HRESP with HREADY low while a new command sits in AP.
  assign cancel_evt     = dp_valid && HRESP && !HREADY && (ap_trans == TRANS_NONSEQ);
  assign cmd_ready      = bus_accept && !cancel_pending && !HRESET;

  assign HADDR     = ap_addr;
  assign HSIZE     = ap_size;
  assign HTRANS    = ap_trans;
  assign HWRITE    = ap_write;
  assign HWDATA    = dp_wdata;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_trans <= TRANS_IDLE;
      ap_addr  <= '0;
      ap_write <= 1'b0;
      ap_size  <= '0;
      ap_wdata <= '0;
    end else if (cancel_evt) begin
      ap_trans <= TRANS_IDLE;
    end else if (bus_accept && !cancel_pending) begin
      if (cmd_valid) begin
        ap_trans <= TRANS_NONSEQ;
        ap_addr  <= cmd_addr;
        ap_write <= cmd_write;
        ap_size  <= cmd_size;
        ap_wdata <= cmd_wdata;
      end else begin
        ap_trans <= TRANS_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (HREADY) begin
      dp_valid <= (ap_trans == TRANS_NONSEQ);
      if (ap_trans == TRANS_NONSEQ) begin
        dp_write <= ap_write;
        dp_wdata <= ap_wdata;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) cxl_state <= CXL_IDLE;
    else        cxl_state <= cxl_next;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    cxl_next = cxl_state;
    case (cxl_state)
      CXL_IDLE:   if (cancel_evt) cxl_next = CXL_WAIT;
      CXL_WAIT:   if (dp_done)    cxl_next = CXL_REPORT;
      CXL_REPORT: cxl_next = CXL_IDLE;
      default:    cxl_next = CXL_IDLE;
    endcase
  end

  // Completion and cancel report are mutually exclusive: AP is IDLE while a cancel is outstanding.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_done || (cxl_state == CXL_REPORT);
      rsp_err   <= dp_done ? HRESP : (cxl_state == CXL_REPORT);
      rsp_rdata <= (dp_done && !dp_write && !HRESP) ? HRDATA : '0;
    end
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt;
  logic        timeout_q;

  // The flag sets on the stall edge that brings the count to TIMEOUT_CYCLES.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (dp_done) begin
        stall_cnt <= '0;
      end else if (dp_valid && !HREADY) begin
        if (stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
        if (stall_cnt >= TIMEOUT_LIM) timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  // Watchdog not built: flag tied low; the parameter only has meaning with the feature enabled.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master; the slave side is driven cycle by cycle.
`timescale 1ns/1ps
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  ahb_lite_master #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HPROT     (HPROT),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .timeout   (timeout)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Advance to just after the next rising edge; registered outputs are stable there.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = 3'd2;
    cmd_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    step(); step();
    check("rst_htrans",    32'(HTRANS), 32'h0);
    check("rst_haddr",     HADDR, 32'h0);
    check("rst_hwdata",    HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_timeout",   32'(timeout), 32'h0);
    check("const_hburst",  32'(HBURST), 32'h0);
    check("const_hprot",   32'(HPROT), 32'h3);
    check("const_hlock",   32'(HMASTLOCK), 32'h0);
    HRESET = 1'b0;
    #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // Zero-wait read
    drive_cmd(1'b0, 32'h0000_0010, 32'h0);
    step();
    cmd_valid = 1'b0;
    check("rd_htrans",  32'(HTRANS), 32'h2);
    check("rd_haddr",   HADDR, 32'h10);
    check("rd_hsize",   32'(HSIZE), 32'h2);
    check("rd_hwrite",  32'(HWRITE), 32'h0);
    check("rd_no_rsp1", 32'(rsp_valid), 32'h0);
    step();
    check("rd_dp_idle", 32'(HTRANS), 32'h0);
    HRDATA = 32'hDEAD_BEEF;
    step();
    check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err",   32'(rsp_err), 32'h0);
    HRDATA = '0;
    step();
    check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Back-to-back writes
    drive_cmd(1'b1, 32'h100, 32'h11);
    step();
    drive_cmd(1'b1, 32'h104, 32'h22);
    check("wr1_htrans", 32'(HTRANS), 32'h2);
    check("wr1_haddr",  HADDR, 32'h100);
    check("wr1_hwrite", 32'(HWRITE), 32'h1);
    step();
    cmd_valid = 1'b0;
    check("wr2_htrans", 32'(HTRANS), 32'h2);
    check("wr2_haddr",  HADDR, 32'h104);
    check("wr1_hwdata", HWDATA, 32'h11);
    step();
    check("wr2_hwdata",   HWDATA, 32'h22);
    check("wr1_rsp",      32'(rsp_valid), 32'h1);
    check("wr1_rsp_err",  32'(rsp_err), 32'h0);
    check("wr_bus_idle",  32'(HTRANS), 32'h0);
    step();
    check("wr2_rsp",      32'(rsp_valid), 32'h1);
    check("wr2_rsp_err",  32'(rsp_err), 32'h0);
    check("wr2_rdata",    rsp_rdata, 32'h0);
    step();
    check("wr_rsp_end",   32'(rsp_valid), 32'h0);

    // Wait states: R1 stalls 3 cycles while R2 holds in AP and R3 waits
    drive_cmd(1'b0, 32'h200, 32'h0);
    step();
    drive_cmd(1'b0, 32'h204, 32'h0);
    step();
    drive_cmd(1'b0, 32'h208, 32'h0);
    HREADY = 1'b0;
    #1;
    check("ws_ready0", 32'(cmd_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("ws_haddr",  HADDR, 32'h204);
      check("ws_htrans", 32'(HTRANS), 32'h2);
      check("ws_ready",  32'(cmd_ready), 32'h0);
      check("ws_no_rsp", 32'(rsp_valid), 32'h0);
    end
    step();
    HREADY = 1'b1;
    HRDATA = 32'hA5A5_0001;
    #1;
    check("ws_ready1", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
    check("ws_r1_rsp",   32'(rsp_valid), 32'h1);
    check("ws_r1_rdata", rsp_rdata, 32'hA5A5_0001);
    check("ws_r3_haddr", HADDR, 32'h208);
    HRDATA = 32'h0000_0002;
    step();
    check("ws_r2_rsp",   32'(rsp_valid), 32'h1);
    check("ws_r2_rdata", rsp_rdata, 32'h2);
    HRDATA = 32'h0000_0003;
    step();
    check("ws_r3_rsp",   32'(rsp_valid), 32'h1);
    check("ws_r3_rdata", rsp_rdata, 32'h3);
    check("ws_idle",     32'(HTRANS), 32'h0);
    HRDATA = '0;
    step();

    // Error with cancel of the pipelined read
    drive_cmd(1'b1, 32'h300, 32'h33);
    step();
    drive_cmd(1'b0, 32'h304, 32'h0);
    step();
    cmd_valid = 1'b0;
    check("err_rd_ap", HADDR, 32'h304);
    HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'h1234_5678;
    step();
    check("err_cancel_idle", 32'(HTRANS), 32'h0);
    check("err_ready0",      32'(cmd_ready), 32'h0);
    HREADY = 1'b1;
    step();
    check("err_rsp1",       32'(rsp_valid), 32'h1);
    check("err_rsp1_err",   32'(rsp_err), 32'h1);
    check("err_rsp1_rdata", rsp_rdata, 32'h0);
    HRESP = 1'b0; HRDATA = '0;
    #1;
    check("err_ready_hold", 32'(cmd_ready), 32'h0);
    step();
    check("err_rsp2",     32'(rsp_valid), 32'h1);
    check("err_rsp2_err", 32'(rsp_err), 32'h1);
    check("err_idle",     32'(HTRANS), 32'h0);
    check("err_ready1",   32'(cmd_ready), 32'h1);
    step();
    check("err_rsp_end",  32'(rsp_valid), 32'h0);
    check("err_no_read",  32'(HTRANS), 32'h0);

    // Reset during a data-phase wait state
    drive_cmd(1'b0, 32'h400, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    HREADY = 1'b0;
    HRESET = 1'b1;
    step();
    check("rst_mid_htrans", 32'(HTRANS), 32'h0);
    check("rst_mid_rsp",    32'(rsp_valid), 32'h0);
    check("rst_mid_ready",  32'(cmd_ready), 32'h0);
    HREADY = 1'b1;
    step();
    HRESET = 1'b0;
    step();
    check("rst_after_rsp", 32'(rsp_valid), 32'h0);
    drive_cmd(1'b0, 32'h500, 32'h0);
    step();
    cmd_valid = 1'b0;
    check("rst_new_haddr", HADDR, 32'h500);
    check("rst_new_trans", 32'(HTRANS), 32'h2);
    step();
    HRDATA = 32'h0000_0055;
    step();
    check("rst_new_rsp",   32'(rsp_valid), 32'h1);
    check("rst_new_rdata", rsp_rdata, 32'h55);
    HRDATA = '0;
    step();

    // Long stall: 10 wait cycles against an 8-cycle watchdog
    drive_cmd(1'b0, 32'h600, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    HREADY = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
`ifdef AHB_MASTER_TIMEOUT_EN
      if (i == 7) check("to_before", 32'(timeout), 32'h0);
      if (i == 8) check("to_rise",   32'(timeout), 32'h1);
`endif
    end
    HREADY = 1'b1;
    HRDATA = 32'h0000_0066;
    step();
    check("to_rsp",   32'(rsp_valid), 32'h1);
    check("to_rdata", rsp_rdata, 32'h66);
    step();
`ifdef AHB_MASTER_TIMEOUT_EN
    check("to_sticky", 32'(timeout), 32'h1);
`else
    check("to_tied0",  32'(timeout), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
